// File: rtl/mem_pkg.sv
// Shared types and constants for the memory arbiter and its clients.
// Ports: none (package).
package mem_pkg;

   typedef logic [11:0] address_t;
   typedef logic [15:0] word_t;

   // Evaluator word tag, carried in the upper bits of a tagged word.
   typedef logic [3:0] tag_t;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2,
      ARB_RESP  = 2'd3
   } arb_state_t;

   localparam logic PORT_EVAL = 1'b0;
   localparam logic PORT_GC   = 1'b1;

   localparam word_t MEM_TIMEOUT_WORD = 16'hEEEE;

   function automatic logic [1:0] port_onehot(input logic id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals of mem_arbiter.
// Requester side: req_valid/req_write/req_addr/req_wdata in, req_ready,
//   rsp_valid/rsp_data/rsp_err out (two ports, index 0 = evaluator, 1 = GC).
// Memory side: mem_req/mem_addr/mem_we/mem_wdata out, mem_ready/mem_rdata/
//   mem_waddr in. busy reports a transaction in flight.
// slave = arbiter view, master = environment (requesters + memory) view.
interface mem_arbiter_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16
);
   logic [1:0]             req_valid;
   logic [1:0]             req_write;
   logic [1:0][ADDR_W-1:0] req_addr;
   logic [1:0][DATA_W-1:0] req_wdata;
   logic [1:0]             req_ready;
   logic [1:0]             rsp_valid;
   logic [DATA_W-1:0]      rsp_data;
   logic                   rsp_err;
   logic                   mem_req;
   logic [ADDR_W-1:0]      mem_addr;
   logic                   mem_we;
   logic [DATA_W-1:0]      mem_wdata;
   logic                   mem_ready;
   logic [DATA_W-1:0]      mem_rdata;
   logic [ADDR_W-1:0]      mem_waddr;
   logic                   busy;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      input  mem_ready, mem_rdata, mem_waddr,
      output req_ready, rsp_valid, rsp_data, rsp_err,
      output mem_req, mem_addr, mem_we, mem_wdata, busy
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      output mem_ready, mem_rdata, mem_waddr,
      input  req_ready, rsp_valid, rsp_data, rsp_err,
      input  mem_req, mem_addr, mem_we, mem_wdata, busy
   );
endinterface

// File: rtl/mem_rr_pick.sv
// Combinational two-way round-robin picker.
// Ports: valid[1:0] request valids, last = port granted most recently,
//   grant_id = chosen port, any = at least one port valid.
module mem_rr_pick
   import mem_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       last,
   output logic       grant_id,
   output logic       any
);
   always_comb begin
      any = |valid;
      case (valid)
         2'b11:   grant_id = ~last;
         2'b10:   grant_id = PORT_GC;
         default: grant_id = PORT_EVAL;
      endcase
   end
endmodule

// File: rtl/mem_arbiter.sv
// Serialises evaluator (port 0) and allocator/collector (port 1) accesses to
// the single-port memory: one transaction outstanding, round-robin on ties,
// watchdog turning a missing data_ready into an error response.
// Ports: clk, rst_n (async, active-low), bus (mem_arbiter_if.slave) carrying
//   the requester handshake, the shared response and the memory strobes.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 255
) (
   input  logic           clk,
   input  logic           rst_n,
   mem_arbiter_if.slave   bus
);
   localparam int             CNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   localparam logic [1:0] S_IDLE  = ARB_IDLE;
   localparam logic [1:0] S_ISSUE = ARB_ISSUE;
   localparam logic [1:0] S_WAIT  = ARB_WAIT;
   localparam logic [1:0] S_RESP  = ARB_RESP;

   logic [1:0]        state_q, state_d;
   logic              last_q, last_d;
   logic              owner_q, owner_d;
   logic              write_q, write_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
   logic [DATA_W-1:0] word_q, word_d;
   logic              err_q, err_d;
   logic [1:0]        grant_pulse;
   logic              grant_id, any;

   // Saturating increment: the watchdog never wraps back to zero.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      if (c == CNT_MAX) return c;
      return c + CNT_W'(1);
   endfunction

   mem_rr_pick u_pick (
      .valid    (bus.req_valid),
      .last     (last_q),
      .grant_id (grant_id),
      .any      (any)
   );

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      owner_d     = owner_q;
      write_d     = write_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cnt_d       = cnt_q;
      word_d      = word_q;
      err_d       = err_q;
      grant_pulse = 2'b00;
      cnt_inc     = sat_inc(cnt_q);
      case (state_q)
         S_IDLE: begin
            if (any) begin
               grant_pulse = port_onehot(grant_id);
               owner_d     = grant_id;
               last_d      = grant_id;
               write_d     = bus.req_write[grant_id];
               addr_d      = bus.req_addr[grant_id];
               wdata_d     = bus.req_wdata[grant_id];
               state_d     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_inc;
            // Data arriving in the timeout cycle still wins.
            if (bus.mem_ready) begin
               word_d  = write_q ? DATA_W'(bus.mem_waddr) : bus.mem_rdata;
               err_d   = 1'b0;
               state_d = S_RESP;
            end else if (cnt_inc == CNT_MAX) begin
               word_d  = DATA_W'(MEM_TIMEOUT_WORD);
               err_d   = 1'b1;
               state_d = S_RESP;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         last_q  <= 1'b1;
         owner_q <= 1'b0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         word_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         err_q   <= err_d;
      end
   end

   // The grant pulse is combinational from req_valid, so it is masked while
   // reset is held to keep every output at zero.
   assign bus.req_ready = rst_n ? grant_pulse : 2'b00;
   assign bus.rsp_valid = (state_q == S_RESP) ? port_onehot(owner_q) : 2'b00;
   assign bus.rsp_data  = word_q;
   assign bus.rsp_err   = err_q;
   assign bus.mem_req   = (state_q == S_ISSUE) && !write_q;
   assign bus.mem_we    = (state_q == S_ISSUE) && write_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a transaction-level model.
module tb_mem_arbiter;
   import mem_pkg::*;

   localparam int AW = 12;
   localparam int DW = 16;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;
   int cyc_n = 0;

   // Memory responder configuration: ready arrives cfg_k cycles after the
   // strobe cycle (0 = never).
   int          cfg_k = 1;
   logic [15:0] cfg_rdata = '0;
   logic [11:0] cfg_waddr = '0;
   bit          rand_mode = 1'b0;
   int          pend = 0;

   typedef struct {
      int          port;
      bit          wr;
      logic [11:0] addr;
      logic [15:0] wdata;
      int          k;
      logic [15:0] rdata;
      logic [11:0] waddr;
      logic [15:0] exp_data;
      bit          exp_err;
      int          exp_lat;
   } vec_t;

   vec_t vt[7];

   function automatic logic [1:0] oh(input int p);
      return (p != 0) ? 2'b10 : 2'b01;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc_n);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      cyc_n++;
      #2;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int nrd, nwr;
      bit got;
      nrd = 0; nwr = 0; got = 1'b0;
      cfg_k = v.k; cfg_rdata = v.rdata; cfg_waddr = v.waddr;
      bus.req_write[v.port] = v.wr;
      bus.req_addr[v.port]  = v.addr;
      bus.req_wdata[v.port] = v.wdata;
      bus.req_valid         = oh(v.port);
      #1;
      chk($sformatf("v%0d_grant", idx), bus.req_ready, oh(v.port));
      for (int c = 1; c <= 30 && !got; c++) begin
         cyc();
         if (c == 1) bus.req_valid = 2'b00;
         #1;
         if (bus.mem_req) begin
            nrd++;
            chk($sformatf("v%0d_mem_addr", idx), bus.mem_addr, v.addr);
         end
         if (bus.mem_we) begin
            nwr++;
            chk($sformatf("v%0d_mem_wdata", idx), bus.mem_wdata, v.wdata);
         end
         if (bus.rsp_valid != 2'b00) begin
            got = 1'b1;
            chk($sformatf("v%0d_latency", idx), c, v.exp_lat);
            chk($sformatf("v%0d_owner", idx), bus.rsp_valid, oh(v.port));
            chk($sformatf("v%0d_data", idx), bus.rsp_data, v.exp_data);
            chk($sformatf("v%0d_err", idx), bus.rsp_err, v.exp_err);
         end
      end
      chk($sformatf("v%0d_rsp_seen", idx), got, 1);
      chk($sformatf("v%0d_rd_strobes", idx), nrd, v.wr ? 0 : 1);
      chk($sformatf("v%0d_wr_strobes", idx), nwr, v.wr ? 1 : 0);
      cyc();
   endtask

   // Memory model: one-cycle data_ready pulse a configured delay after a strobe.
   initial begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      bus.mem_waddr = '0;
      forever begin
         @(negedge clk);
         bus.mem_ready = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               bus.mem_ready = 1'b1;
               bus.mem_rdata = cfg_rdata;
               bus.mem_waddr = cfg_waddr;
            end
         end
         if (bus.mem_req || bus.mem_we) begin
            if (rand_mode) begin
               cfg_k     = $urandom_range(1, 11);
               cfg_rdata = 16'($urandom);
               cfg_waddr = 12'($urandom);
            end
            pend = cfg_k;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got stuck, expected finish (cycle %0d)", cyc_n);
      $fatal(1, "bench time limit");
   end

   initial begin
      int ng, nr, last_c, last_owner;
      int exp_order[4];
      bit got, outstanding, mlast, g_wr, gen, err;
      bit [1:0] pend_r, v;
      int g_owner, strobe_c, exp_g;
      logic [11:0] g_addr;
      logic [15:0] g_wdata, exp_d;

      vt[0] = '{0, 1'b0, 12'h004, 16'h0000, 2,  16'h1234, 12'h777, 16'h1234, 1'b0, 4};
      vt[1] = '{1, 1'b1, 12'h000, 16'hBEEF, 1,  16'h0000, 12'h010, 16'h0010, 1'b0, 3};
      vt[2] = '{0, 1'b1, 12'h3C3, 16'h5A5A, 5,  16'hFFFF, 12'hFFF, 16'h0FFF, 1'b0, 7};
      vt[3] = '{1, 1'b0, 12'hABC, 16'h0000, 8,  16'h8001, 12'h001, 16'h8001, 1'b0, 10};
      vt[4] = '{0, 1'b0, 12'h123, 16'h0000, 0,  16'h4444, 12'h000, 16'hEEEE, 1'b1, 10};
      vt[5] = '{0, 1'b0, 12'h7FF, 16'h0000, 3,  16'h0000, 12'h000, 16'h0000, 1'b0, 5};
      vt[6] = '{1, 1'b0, 12'h055, 16'h0000, 12, 16'h9999, 12'h000, 16'hEEEE, 1'b1, 10};

      bus.req_valid = 2'b00;
      bus.req_write = 2'b00;
      bus.req_addr  = '0;
      bus.req_wdata = '0;

      // Reset state, including a request presented while reset is held.
      repeat (2) cyc();
      bus.req_valid = 2'b11;
      #1;
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_data", bus.rsp_data, 0);
      chk("rst_rsp_err", bus.rsp_err, 0);
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_busy", bus.busy, 0);
      bus.req_valid = 2'b00;
      cyc();
      rst_n = 1'b1;
      cyc();

      for (int i = 0; i < 7; i++) run_vec(i, vt[i]);

      // Late ready after the timeout response must be ignored.
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("late_ready_rsp", bus.rsp_valid, 0);
         chk("late_ready_busy", bus.busy, 0);
         cyc();
      end

      // Contention: both ports valid continuously for four transactions.
      exp_order = '{0, 1, 0, 1};
      cfg_k = 1; cfg_rdata = 16'h0A0A; cfg_waddr = 12'h0B0;
      bus.req_write = 2'b10;
      bus.req_addr[0] = 12'h100;
      bus.req_wdata[1] = 16'hC0DE;
      bus.req_valid = 2'b11;
      ng = 0; nr = 0; last_c = 0; last_owner = 0;
      for (int c = 0; c < 40 && nr < 4; c++) begin
         if (ng == 4) bus.req_valid = 2'b00;
         #1;
         if (bus.req_ready != 2'b00 && ng < 4) begin
            chk($sformatf("cont_grant%0d", ng), bus.req_ready, oh(exp_order[ng]));
            if (ng > 0) chk($sformatf("cont_spacing%0d", ng), c - last_c, 4);
            last_c = c;
            last_owner = exp_order[ng];
            ng++;
         end
         if (bus.rsp_valid != 2'b00) begin
            chk($sformatf("cont_owner%0d", nr), bus.rsp_valid, oh(last_owner));
            chk($sformatf("cont_data%0d", nr), bus.rsp_data, (last_owner != 0) ? 16'h00B0 : 16'h0A0A);
            nr++;
         end
         cyc();
      end
      chk("cont_rsp_count", nr, 4);
      bus.req_valid = 2'b00;
      cyc();

      // Reset in WAIT: outputs clear at once, arbitration restarts at port 0.
      cfg_k = 0;
      bus.req_write = 2'b00;
      bus.req_addr[0] = 12'h222;
      bus.req_valid = 2'b01;
      #1;
      chk("rw_grant", bus.req_ready, 2'b01);
      cyc();
      bus.req_valid = 2'b00;
      cyc();
      cyc();
      #1;
      chk("rw_busy_before", bus.busy, 1);
      rst_n = 1'b0;
      #1;
      chk("rw_busy", bus.busy, 0);
      chk("rw_mem_req", bus.mem_req, 0);
      chk("rw_mem_we", bus.mem_we, 0);
      chk("rw_mem_addr", bus.mem_addr, 0);
      chk("rw_mem_wdata", bus.mem_wdata, 0);
      chk("rw_rsp_valid", bus.rsp_valid, 0);
      chk("rw_rsp_data", bus.rsp_data, 0);
      chk("rw_rsp_err", bus.rsp_err, 0);
      cyc();
      rst_n = 1'b1;
      cfg_k = 2; cfg_rdata = 16'h5150;
      bus.req_addr[0] = 12'h033;
      bus.req_addr[1] = 12'h044;
      bus.req_valid = 2'b11;
      #1;
      chk("rw_first_grant", bus.req_ready, 2'b01);
      got = 1'b0;
      for (int c = 1; c <= 20 && !got; c++) begin
         cyc();
         if (c == 1) bus.req_valid = 2'b00;
         #1;
         if (bus.rsp_valid != 2'b00) begin
            got = 1'b1;
            chk("rw_after_owner", bus.rsp_valid, 2'b01);
            chk("rw_after_data", bus.rsp_data, 16'h5150);
            chk("rw_after_err", bus.rsp_err, 0);
            chk("rw_after_latency", c, 4);
         end
      end
      chk("rw_after_seen", got, 1);
      cyc();

      // Randomized traffic against a transaction-level model.
      rand_mode = 1'b1;
      outstanding = 1'b0;
      mlast = 1'b0;
      pend_r = 2'b00;
      g_owner = 0; g_wr = 1'b0; g_addr = '0; g_wdata = '0; strobe_c = 0;
      for (int c = 0; c < 2400; c++) begin
         gen = (c < 1600);
         if (!gen && !outstanding && pend_r == 2'b00) break;
         for (int p = 0; p < 2; p++) begin
            if (!pend_r[p]) bus.req_valid[p] = 1'b0;
            if (!pend_r[p] && gen && $urandom_range(0, 2) == 0) begin
               pend_r[p] = 1'b1;
               bus.req_valid[p] = 1'b1;
               bus.req_write[p] = 1'($urandom);
               bus.req_addr[p]  = 12'($urandom);
               bus.req_wdata[p] = 16'($urandom);
            end
         end
         #1;
         v = bus.req_valid;
         if (!outstanding && v != 2'b00) begin
            exp_g = (v == 2'b11) ? int'(!mlast) : int'(v[1]);
            chk("rnd_grant", bus.req_ready, oh(exp_g));
            outstanding = 1'b1;
            g_owner = exp_g;
            g_wr    = bus.req_write[exp_g];
            g_addr  = bus.req_addr[exp_g];
            g_wdata = bus.req_wdata[exp_g];
            mlast   = exp_g[0];
            pend_r[exp_g] = 1'b0;
         end else begin
            chk("rnd_no_grant", bus.req_ready, 0);
         end
         if (bus.mem_req || bus.mem_we) begin
            chk("rnd_strobe_kind", {bus.mem_we, bus.mem_req}, g_wr ? 2'b10 : 2'b01);
            if (g_wr) chk("rnd_wdata", bus.mem_wdata, g_wdata);
            else      chk("rnd_addr", bus.mem_addr, g_addr);
            strobe_c = c;
         end
         if (bus.rsp_valid != 2'b00) begin
            chk("rnd_rsp_expected", outstanding, 1);
            err   = (cfg_k > TO);
            exp_d = err ? 16'hEEEE : (g_wr ? {4'h0, cfg_waddr} : cfg_rdata);
            chk("rnd_owner", bus.rsp_valid, oh(g_owner));
            chk("rnd_latency", c - strobe_c, err ? TO + 1 : cfg_k + 1);
            chk("rnd_err", bus.rsp_err, err);
            chk("rnd_data", bus.rsp_data, exp_d);
            outstanding = 1'b0;
         end
         cyc();
      end
      chk("rnd_drained", {outstanding, pend_r}, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
